bp_update_gen: RTL and testbench
================================

BP_UPDATE_GEN -- requirements
Module: bp_update_gen

Interface
REQ-001 SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, core configuration.
REQ-002 SHALL have parameter bht_update_t, default logic, update packet type {valid, pc, taken, metadata}.
REQ-003 SHALL have parameter bp_metadata_t, default logic, per-branch predictor metadata type.
REQ-004 SHALL have parameter DEPTH, default 8, in-flight branch entries (power of two, >=2).
REQ-005 SHALL have port clk_i  in  1  the single clock.
REQ-006 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port flush_i  in  1  frontend flush; discards all in-flight entries.
REQ-008 SHALL have port debug_mode_i  in  1  suppresses predictor updates while high.
REQ-009 SHALL have port push_valid_i  in  1  frontend records a predicted conditional branch.
REQ-010 SHALL have port push_ready_o  out  1  entry accepted when push_valid_i & push_ready_o.
REQ-011 SHALL have port push_pc_i  in  VLEN  branch PC.
REQ-012 SHALL have port push_metadata_i  in  $bits(bp_metadata_t)  prediction-time metadata.
REQ-013 SHALL have port resolve_valid_i  in  1  execute resolved the oldest conditional branch.
REQ-014 SHALL have port resolve_pc_i  in  VLEN  resolved branch PC.
REQ-015 SHALL have port resolve_taken_i  in  1  resolved direction.
REQ-016 SHALL have port bht_update_o  out  $bits(bht_update_t)  update packet to the predictor.
REQ-017 SHALL have port resync_o  out  1  high while in RESYNC.
REQ-018 SHALL have port count_o  out  $clog2(DEPTH+1)  current occupancy.

Function
REQ-019 SHALL hold entries {pc, metadata} in a circular FIFO; pointers wrap modulo DEPTH; count is tracked separately, so full and empty are unambiguous.
REQ-020 SHALL assert push_ready_o = (state==RUN) & (count<DEPTH) & ~flush_i; there is no same-cycle pop bypass when full.
REQ-021 SHALL, on resolve_valid_i in RUN with count>0 and resolve_pc_i == head pc, pop the head and register bht_update_o = {valid=~debug_mode_i, pc=head pc, taken=resolve_taken_i, metadata=head metadata} at the next edge.
REQ-022 SHALL make bht_update_o.valid a single-cycle pulse; otherwise it is 0 and the remaining fields hold their last value.
REQ-023 SHALL, on resolve_valid_i in RUN with count==0 or a pc mismatch, emit no update and transition to RESYNC.
REQ-024 SHALL, in RESYNC, ignore resolve_valid_i, hold push_ready_o low, and return to RUN with count=0 on flush_i.
REQ-025 SHALL, on a simultaneous push and matching resolve, perform both; count is unchanged.
REQ-026 SHALL, on simultaneous flush_i and matching resolve, issue that update, then set count=0 and both pointers to 0 at the same edge.
REQ-027 SHALL, on flush_i alone in RUN, empty the FIFO next cycle and emit no update.
REQ-028 SHALL give push-to-resolvable latency of 1 cycle: an entry pushed at edge N can be resolved in the cycle after N.

Reset
REQ-029 SHALL, on rst_i high at a clock edge: state=RUN, count_o=0, pointers=0, bht_update_o=0 (all fields), resync_o=0.
REQ-030 SHALL let rst_i override flush, push and resolve in the same cycle; FIFO payload storage need not be reset.

Structure
REQ-031 SHALL take bht_update_t and bp_metadata_t as parameters, defined in the frontend package alongside the tournament metadata fields (gindex, lindex, gbp/lbp valid/taken).
REQ-032 SHALL define the state enum {RUN, RESYNC} locally in the module.
REQ-033 SHALL use one natural sub-module, bp_meta_fifo (circular buffer with count), instantiated once.

Verification
REQ-034 SHALL cover: reset, then push pc 0x100 with meta M1, resolve pc 0x100 taken=1 -> one cycle later bht_update_o = {1, 0x100, 1, M1}, count_o=0.
REQ-035 SHALL cover: push 8 branches with DEPTH=8 -> push_ready_o=0 and count_o=8; one matching resolve -> push_ready_o=1 the next cycle.
REQ-036 SHALL cover: push 0x100, resolve pc 0x104 -> no update, resync_o=1, push_ready_o=0; flush_i -> RUN with count_o=0.
REQ-037 SHALL cover: 3 entries queued, flush_i together with a matching resolve of the head -> one update for the head, then count_o=0.
REQ-038 SHALL cover: debug_mode_i=1 with a matching resolve -> entry popped and bht_update_o.valid=0.
REQ-039 SHALL cover: 20 back-to-back push+resolve pairs with DEPTH=8 -> pointers wrap, every update matches its PC in order, count_o stays constant.

Source files
------------

// File: rtl/bp_update_gen_pkg.sv
// Frontend types shared by the branch-predictor update generator: core config,
// tournament predictor metadata and the update packet sent back to the BHT.
package bp_update_gen_pkg;

    typedef struct packed {
        int unsigned VLEN;
    } cva6_cfg_t;

    localparam int unsigned DEFAULT_VLEN = 32;
    localparam int unsigned GINDEX_W     = 8;
    localparam int unsigned LINDEX_W     = 6;

    localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: DEFAULT_VLEN};

    typedef struct packed {
        logic [GINDEX_W-1:0] gindex;
        logic [LINDEX_W-1:0] lindex;
        logic                gbp_valid;
        logic                gbp_taken;
        logic                lbp_valid;
        logic                lbp_taken;
    } tour_metadata_t;

    typedef struct packed {
        logic                    valid;
        logic [DEFAULT_VLEN-1:0] pc;
        logic                    taken;
        tour_metadata_t          metadata;
    } bht_update_pkt_t;

endpackage

// File: rtl/bp_meta_fifo.sv
// Circular buffer of in-flight branch entries; occupancy kept in its own counter
// so full and empty never alias. Payload storage is deliberately not reset.
module bp_meta_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             wdata_i,
    output logic [WIDTH-1:0]             head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    // Payload write
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            r_mem[r_wptr] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; clear beats push/pop
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push_i) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (pop_i) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= r_count + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_o  = r_mem[r_rptr];
    assign count_o = r_count;

endmodule

// File: rtl/bp_update_gen.sv
// Pairs each resolved conditional branch with the metadata captured at prediction
// time and emits a one-cycle predictor update; desynchronisation parks in RESYNC.
module bp_update_gen
    import bp_update_gen_pkg::*;
#(
    parameter cva6_cfg_t CVA6Cfg       = bp_update_gen_pkg::cva6_cfg_empty,
    parameter type       bht_update_t  = bp_update_gen_pkg::bht_update_pkt_t,
    parameter type       bp_metadata_t = bp_update_gen_pkg::tour_metadata_t,
    parameter int unsigned DEPTH       = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             flush_i,
    input  logic                             debug_mode_i,
    input  logic                             push_valid_i,
    output logic                             push_ready_o,
    input  logic [CVA6Cfg.VLEN-1:0]          push_pc_i,
    input  logic [$bits(bp_metadata_t)-1:0]  push_metadata_i,
    input  logic                             resolve_valid_i,
    input  logic [CVA6Cfg.VLEN-1:0]          resolve_pc_i,
    input  logic                             resolve_taken_i,
    output logic [$bits(bht_update_t)-1:0]   bht_update_o,
    output logic                             resync_o,
    output logic [$clog2(DEPTH+1)-1:0]       count_o
);
    localparam int unsigned CW = $clog2(DEPTH+1);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        RESYNC = 1'b1
    } state_e;

    typedef struct packed {
        logic [CVA6Cfg.VLEN-1:0] pc;
        bp_metadata_t            meta;
    } entry_t;

    state_e      r_state;
    state_e      w_state_next;
    entry_t      w_push_entry;
    entry_t      w_head;
    logic [CW-1:0] w_count;
    bht_update_t r_update;
    logic        w_push;
    logic        w_match;
    logic        w_mismatch;

    assign w_push_entry = '{pc: push_pc_i, meta: bp_metadata_t'(push_metadata_i)};

    // No pop bypass: a full FIFO refuses pushes even when the head resolves this cycle
    assign push_ready_o = (r_state == RUN) && (w_count < CW'(DEPTH)) && !flush_i;
    assign w_push       = push_valid_i && push_ready_o;
    assign w_match      = resolve_valid_i && (r_state == RUN) && (w_count != '0)
                          && (resolve_pc_i == w_head.pc);
    assign w_mismatch   = resolve_valid_i && (r_state == RUN) && !w_match;

    bp_meta_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (flush_i),
        .push_i  (w_push),
        .pop_i   (w_match),
        .wdata_i (w_push_entry),
        .head_o  (w_head),
        .count_o (w_count)
    );

    // Next-state: a flush always lands back in RUN with an empty FIFO
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN: begin
                if (w_mismatch && !flush_i) begin
                    w_state_next = RESYNC;
                end else begin
                    w_state_next = RUN;
                end
            end
            RESYNC: begin
                if (flush_i) begin
                    w_state_next = RUN;
                end else begin
                    w_state_next = RESYNC;
                end
            end
            default: w_state_next = RUN;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Update packet: valid pulses for one cycle, payload holds between updates
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_update <= '0;
        end else if (w_match) begin
            r_update.valid    <= !debug_mode_i;
            r_update.pc       <= w_head.pc;
            r_update.taken    <= resolve_taken_i;
            r_update.metadata <= w_head.meta;
        end else begin
            r_update.valid    <= 1'b0;
        end
    end

    assign bht_update_o = r_update;
    assign resync_o     = (r_state == RESYNC);
    assign count_o      = w_count;

endmodule

// File: tb/tb_bp_update_gen.sv
// Self-checking bench for bp_update_gen: directed vector table, hand-written
// full/wrap/reset sequences, then random traffic against a queue-based model.
module tb_bp_update_gen;
    import bp_update_gen_pkg::*;

    localparam int DEPTH = 8;
    localparam int VLEN  = DEFAULT_VLEN;
    localparam int MW    = $bits(tour_metadata_t);
    localparam int UW    = $bits(bht_update_pkt_t);
    localparam int CW    = $clog2(DEPTH+1);

    localparam logic [MW-1:0] M1 = 18'h1A5A5;
    localparam logic [MW-1:0] M2 = 18'h02345;
    localparam logic [MW-1:0] M3 = 18'h3FFFF;
    localparam logic [MW-1:0] M4 = 18'h00001;
    localparam logic [MW-1:0] M5 = 18'h2AAAA;
    localparam logic [MW-1:0] M6 = 18'h15555;
    localparam logic [MW-1:0] M7 = 18'h0F0F0;
    localparam logic [MW-1:0] M8 = 18'h30303;

    logic            clk = 1'b0;
    logic            rst, flush, dbg, pv, rv, rt;
    logic [VLEN-1:0] ppc, rpc;
    logic [MW-1:0]   pm;
    logic            ready, resync;
    logic [UW-1:0]   upd_o;
    logic [CW-1:0]   cnt;
    bht_update_pkt_t upd;

    assign upd = upd_o;

    bp_update_gen #(.DEPTH(DEPTH)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .flush_i         (flush),
        .debug_mode_i    (dbg),
        .push_valid_i    (pv),
        .push_ready_o    (ready),
        .push_pc_i       (ppc),
        .push_metadata_i (pm),
        .resolve_valid_i (rv),
        .resolve_pc_i    (rpc),
        .resolve_taken_i (rt),
        .bht_update_o    (upd_o),
        .resync_o        (resync),
        .count_o         (cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic f, input logic d, input logic p, input logic [31:0] pp,
                          input logic [MW-1:0] m, input logic r, input logic [31:0] rp,
                          input logic t);
        @(negedge clk);
        flush = f; dbg = d; pv = p; ppc = pp; pm = m; rv = r; rpc = rp; rt = t;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_upd(input string name, input logic v, input logic [31:0] pc,
                           input logic t, input logic [MW-1:0] m);
        chk({name, ".valid"}, upd.valid, v);
        if (v) begin
            chk({name, ".pc"}, upd.pc, pc);
            chk({name, ".taken"}, upd.taken, t);
            chk({name, ".meta"}, upd.metadata, m);
        end
    endtask

    typedef struct {
        logic f, d, p; logic [31:0] ppc; logic [MW-1:0] pm;
        logic r; logic [31:0] rpc; logic rt;
        logic e_ready; logic [CW-1:0] e_cnt; logic e_resync;
        logic e_uv; logic [31:0] e_upc; logic e_ut; logic [MW-1:0] e_um;
    } vec_t;

    function automatic vec_t v(input logic f, input logic d, input logic p, input logic [31:0] pp,
                               input logic [MW-1:0] m, input logic r, input logic [31:0] rp,
                               input logic t, input logic er, input logic [CW-1:0] ec,
                               input logic ers, input logic euv, input logic [31:0] eupc,
                               input logic eut, input logic [MW-1:0] eum);
        vec_t x;
        x.f = f; x.d = d; x.p = p; x.ppc = pp; x.pm = m; x.r = r; x.rpc = rp; x.rt = t;
        x.e_ready = er; x.e_cnt = ec; x.e_resync = ers;
        x.e_uv = euv; x.e_upc = eupc; x.e_ut = eut; x.e_um = eum;
        return x;
    endfunction

    typedef struct { logic [31:0] pc; logic [MW-1:0] meta; } ent_t;

    initial begin
        vec_t        vecs[$];
        ent_t        mq[$];
        logic        m_resync, f, d, p, r, t, match, e_ready, e_uv, e_ut;
        logic [31:0] pp, rp, e_pc;
        logic [MW-1:0] m, e_m;

        rst = 1'b1; flush = 1'b0; dbg = 1'b0; pv = 1'b0; rv = 1'b0; rt = 1'b0;
        ppc = '0; rpc = '0; pm = '0;
        tick; tick;
        chk("reset.count", cnt, 0);
        chk("reset.resync", resync, 1'b0);
        chk("reset.update", upd_o, '0);
        @(negedge clk); rst = 1'b0; #1;
        chk("reset.ready", ready, 1'b1);

        // f d p ppc pm r rpc rt | ready cnt resync uv upc ut um
        vecs.push_back(v(0,0,1,32'h100,M1,0,32'h0,0,   1,1,0, 0,32'h0,0,M1));
        vecs.push_back(v(0,0,0,32'h0,M1,1,32'h100,1,   1,0,0, 1,32'h100,1,M1));
        vecs.push_back(v(0,0,0,32'h0,M1,0,32'h0,0,     1,0,0, 0,32'h0,0,M1));
        vecs.push_back(v(0,0,1,32'h100,M2,0,32'h0,0,   1,1,0, 0,32'h0,0,M2));
        vecs.push_back(v(0,0,0,32'h0,M2,1,32'h104,1,   1,1,1, 0,32'h0,0,M2));
        vecs.push_back(v(0,0,1,32'h108,M2,0,32'h0,0,   0,1,1, 0,32'h0,0,M2));
        vecs.push_back(v(0,0,0,32'h0,M2,1,32'h100,1,   0,1,1, 0,32'h0,0,M2));
        vecs.push_back(v(1,0,0,32'h0,M2,0,32'h0,0,     0,0,0, 0,32'h0,0,M2));
        vecs.push_back(v(0,0,0,32'h0,M2,0,32'h0,0,     1,0,0, 0,32'h0,0,M2));
        vecs.push_back(v(0,0,1,32'h200,M3,0,32'h0,0,   1,1,0, 0,32'h0,0,M3));
        vecs.push_back(v(0,0,1,32'h204,M4,0,32'h0,0,   1,2,0, 0,32'h0,0,M4));
        vecs.push_back(v(0,0,1,32'h208,M5,0,32'h0,0,   1,3,0, 0,32'h0,0,M5));
        vecs.push_back(v(1,0,0,32'h0,M5,1,32'h200,0,   0,0,0, 1,32'h200,0,M3));
        vecs.push_back(v(0,0,0,32'h0,M5,0,32'h0,0,     1,0,0, 0,32'h0,0,M5));
        vecs.push_back(v(0,0,1,32'h300,M6,0,32'h0,0,   1,1,0, 0,32'h0,0,M6));
        vecs.push_back(v(0,1,0,32'h0,M6,1,32'h300,1,   1,0,0, 0,32'h0,0,M6));
        vecs.push_back(v(0,0,1,32'h400,M7,0,32'h0,0,   1,1,0, 0,32'h0,0,M7));
        vecs.push_back(v(0,0,1,32'h404,M8,1,32'h400,1, 1,1,0, 1,32'h400,1,M7));
        vecs.push_back(v(0,0,0,32'h0,M8,1,32'h404,0,   1,0,0, 1,32'h404,0,M8));
        vecs.push_back(v(0,0,0,32'h0,M8,1,32'h500,1,   1,0,1, 0,32'h0,0,M8));
        vecs.push_back(v(1,0,0,32'h0,M8,0,32'h0,0,     0,0,0, 0,32'h0,0,M8));

        foreach (vecs[i]) begin
            set_in(vecs[i].f, vecs[i].d, vecs[i].p, vecs[i].ppc, vecs[i].pm,
                   vecs[i].r, vecs[i].rpc, vecs[i].rt);
            chk($sformatf("vec%0d.ready", i), ready, vecs[i].e_ready);
            tick;
            chk($sformatf("vec%0d.count", i), cnt, vecs[i].e_cnt);
            chk($sformatf("vec%0d.resync", i), resync, vecs[i].e_resync);
            chk_upd($sformatf("vec%0d.upd", i), vecs[i].e_uv, vecs[i].e_upc, vecs[i].e_ut, vecs[i].e_um);
        end

        // Fill to DEPTH: ready drops, a blocked push is not taken, one pop reopens it
        for (int i = 0; i < DEPTH; i++) begin
            set_in(0, 0, 1, 32'h1000 + 32'(4*i), MW'(i), 0, 32'h0, 0);
            tick;
        end
        chk("full.count", cnt, DEPTH);
        set_in(0, 0, 1, 32'h2000, M1, 0, 32'h0, 0);
        chk("full.ready", ready, 1'b0);
        tick;
        chk("full.blocked_count", cnt, DEPTH);
        set_in(0, 0, 0, 32'h0, M1, 1, 32'h1000, 1);
        chk("full.ready_at_pop", ready, 1'b0);
        tick;
        chk_upd("full.pop", 1'b1, 32'h1000, 1'b1, MW'(0));
        set_in(0, 0, 0, 32'h0, M1, 0, 32'h0, 0);
        chk("full.ready_after_pop", ready, 1'b1);
        for (int i = 1; i < DEPTH; i++) begin
            set_in(0, 0, 0, 32'h0, M1, 1, 32'h1000 + 32'(4*i), 0);
            tick;
            chk_upd($sformatf("drain%0d", i), 1'b1, 32'h1000 + 32'(4*i), 1'b0, MW'(i));
        end
        chk("drain.count", cnt, 0);

        // Back-to-back push+resolve with three queued: pointers wrap, order preserved
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 1, 32'h3000 + 32'(4*i), MW'(100+i), 0, 32'h0, 0);
            tick;
        end
        for (int j = 0; j < 20; j++) begin
            set_in(0, 0, 1, 32'h3000 + 32'(4*(j+3)), MW'(100+j+3), 1, 32'h3000 + 32'(4*j), j[0]);
            tick;
            chk_upd($sformatf("wrap%0d", j), 1'b1, 32'h3000 + 32'(4*j), j[0], MW'(100+j));
            chk($sformatf("wrap%0d.count", j), cnt, 3);
        end
        set_in(1, 0, 0, 32'h0, M1, 0, 32'h0, 0);
        tick;

        // Randomised traffic against a queue model
        mq.delete();
        m_resync = 1'b0;
        for (int c = 0; c < 600; c++) begin
            f  = ($urandom_range(0, 29) == 0);
            d  = ($urandom_range(0, 9) == 0);
            p  = ($urandom_range(0, 2) != 0);
            r  = ($urandom_range(0, 2) != 0);
            t  = $urandom_range(0, 1);
            pp = 32'h8000_0000 | ($urandom & 32'h0000_fffc);
            m  = MW'($urandom);
            if (mq.size() > 0 && $urandom_range(0, 19) != 0) rp = mq[0].pc;
            else rp = 32'h8000_0000 | ($urandom & 32'h0000_fffc);

            e_ready = !m_resync && (mq.size() < DEPTH) && !f;
            match   = r && !m_resync && (mq.size() > 0) && (rp == mq[0].pc);
            e_uv = 1'b0; e_pc = '0; e_ut = 1'b0; e_m = '0;
            if (match) begin
                e_uv = !d; e_pc = mq[0].pc; e_ut = t; e_m = mq[0].meta;
                void'(mq.pop_front());
            end
            if (e_ready && p) mq.push_back('{pc: pp, meta: m});
            if (f) begin
                mq.delete();
                m_resync = 1'b0;
            end else if (r && !m_resync && !match) begin
                m_resync = 1'b1;
            end

            set_in(f, d, p, pp, m, r, rp, t);
            chk($sformatf("rnd%0d.ready", c), ready, e_ready);
            tick;
            chk($sformatf("rnd%0d.count", c), cnt, mq.size());
            chk($sformatf("rnd%0d.resync", c), resync, m_resync);
            chk_upd($sformatf("rnd%0d.upd", c), e_uv, e_pc, e_ut, e_m);
        end

        // Reset beats simultaneous flush, push and resolve
        set_in(1, 0, 0, 32'h0, M1, 0, 32'h0, 0);
        tick;
        set_in(0, 0, 1, 32'h700, M2, 0, 32'h0, 0);
        tick;
        set_in(1, 0, 1, 32'h704, M3, 1, 32'h700, 1);
        rst = 1'b1;
        tick;
        chk("rst_override.count", cnt, 0);
        chk("rst_override.resync", resync, 1'b0);
        chk("rst_override.update", upd_o, '0);
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; pv = 1'b0; rv = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
